// File: rtl/tag_mem_pkg.sv
// Shared types and default sizing for the tag cache backing memory.
// The defaults here match the tag cache configuration so both sides agree on geometry.
package tag_mem_pkg;

   localparam int MEM_ADDR_W = 26;
   localparam int MEM_TAG_W  = 5;
   localparam int MEM_DATA_W = 128;
   localparam int MEM_BEATS  = 4;
   localparam int MEM_IDX_W  = 10;
   localparam int MEM_RD_LAT = 8;

   typedef enum logic [1:0] {
      IDLE,
      WDATA,
      RWAIT,
      RRESP
   } mem_state_e;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_TAG_W-1:0]  tag;
      logic                  rw;
   } mem_cmd_t;

endpackage

// File: rtl/tag_mem_array.sv
// Line store: one write port and one synchronous read port, one beat per word.
// Contents are deliberately not reset so a reset mid-write leaves earlier beats intact.
module tag_mem_array #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write the addressed beat when enabled and read every cycle into the output register.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/tag_mem_backend.sv
// Backing-memory responder for the tag cache memory port.
// Accepts one command at a time: writes take BEATS data beats, reads return BEATS
// beats tagged with the request tag after a programmable latency.
module tag_mem_backend
   import tag_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int TAG_W  = MEM_TAG_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int BEATS  = MEM_BEATS,
   parameter int IDX_W  = MEM_IDX_W,
   parameter int RD_LAT = MEM_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [TAG_W-1:0]  cmd_tag,
   input  logic              cmd_rw,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DATA_W-1:0] data_bits,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_tag
);

   localparam int BW    = $clog2(BEATS);
   localparam int LAT_W = $clog2(RD_LAT + 1);
   localparam int AW    = IDX_W + BW;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   mem_state_e        state;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag_q;
   logic [BW-1:0]     beat;
   logic [BW-1:0]     beat_next;
   logic [LAT_W-1:0]  lat_cnt;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;
   logic              unused_addr_hi;

   // Address bits above the line index alias onto the same line.
   assign unused_addr_hi = ^cmd_addr[ADDR_W-1:IDX_W];

   assign wr_en     = (state == WDATA) && data_valid && data_ready;
   assign resp_data = resp_valid ? rd_data : '0;

   // Beat the read port should present next cycle: advance only on an accepted response beat.
   always_comb begin
      beat_next = beat;
      if ((state == RRESP) && resp_valid && resp_ready) begin
         beat_next = beat + BW'(1);
      end
   end

   tag_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (AW)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr ({idx, beat}),
      .wr_data (data_bits),
      .rd_addr ({idx, beat_next}),
      .rd_data (rd_data)
   );

   // Request sequencing: command accept, write beats, read latency countdown, response beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         data_ready <= 1'b0;
         resp_valid <= 1'b0;
         resp_tag   <= '0;
         tag_q      <= '0;
         idx        <= '0;
         beat       <= '0;
         lat_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  idx       <= cmd_addr[IDX_W-1:0];
                  tag_q     <= cmd_tag;
                  beat      <= '0;
                  cmd_ready <= 1'b0;
                  if (cmd_rw) begin
                     state      <= WDATA;
                     data_ready <= 1'b1;
                  end else begin
                     state   <= RWAIT;
                     lat_cnt <= LAT_W'(RD_LAT - 1);
                  end
               end
            end
            WDATA: begin
               if (data_valid && data_ready) begin
                  beat <= beat + BW'(1);
                  if (beat == LAST_BEAT) begin
                     state      <= IDLE;
                     data_ready <= 1'b0;
                     cmd_ready  <= 1'b1;
                  end
               end
            end
            RWAIT: begin
               if (lat_cnt == '0) begin
                  state      <= RRESP;
                  resp_valid <= 1'b1;
                  resp_tag   <= tag_q;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            RRESP: begin
               beat <= beat_next;
               if (resp_ready && (beat == LAST_BEAT)) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  cmd_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tag_mem_backend.sv
// Testbench for tag_mem_backend: directed scenarios plus randomized write/read traffic
// checked against a line-level memory model kept in an associative array.
module tb_tag_mem_backend;

   localparam int ADDR_W = 26;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 128;
   localparam int BEATS  = 4;
   localparam int IDX_W  = 10;
   localparam int RD_LAT = 8;

   logic              clk;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [TAG_W-1:0]  cmd_tag;
   logic              cmd_rw;
   logic              data_valid;
   logic              data_ready;
   logic [DATA_W-1:0] data_bits;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic [TAG_W-1:0]  resp_tag;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] model_mem [int];
   logic [DATA_W-1:0] wr_beats  [BEATS];
   logic [DATA_W-1:0] got_data  [BEATS];
   logic [TAG_W-1:0]  got_tag   [BEATS];
   int                got_lat;
   bit                got_stable;
   bit                got_cmd_ready_seen;
   int                written_lines [$];

   tag_mem_backend #(
      .ADDR_W (ADDR_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .IDX_W  (IDX_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_tag    (cmd_tag),
      .cmd_rw     (cmd_rw),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_bits  (data_bits),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Line index the memory model files an address under: upper bits alias.
   function automatic int line_of(input logic [ADDR_W-1:0] a);
      return int'(a % (1 << IDX_W));
   endfunction

   function automatic logic [DATA_W-1:0] rand_beat();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Present a command from a negedge and return at the negedge after its handshake edge.
   task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t, input logic rw);
      int waited;
      waited    = 0;
      cmd_addr  = a;
      cmd_tag   = t;
      cmd_rw    = rw;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (cmd_ready !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL cmd_handshake_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Stream the first n beats of wr_beats and record each accepted beat in the model.
   task automatic send_beats(input int line, input int n);
      int waited;
      for (int b = 0; b < n; b++) begin
         waited     = 0;
         data_bits  = wr_beats[b];
         data_valid = 1'b1;
         while (data_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
         end
         if (data_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL data_handshake_timeout: data_ready=%b required 1", data_ready);
         end
         @(negedge clk);
         model_mem[line * BEATS + b] = wr_beats[b];
      end
      data_valid = 1'b0;
   endtask

   // Measure read latency and gather all beats, optionally stalling one beat.
   task automatic collect_read(input int stall_beat, input int stall_cycles);
      int                waited;
      logic [DATA_W-1:0] hold_d;
      logic [TAG_W-1:0]  hold_t;
      got_stable         = 1'b1;
      got_cmd_ready_seen = (cmd_ready === 1'b1);
      got_lat            = 0;
      resp_ready         = 1'b1;
      while (resp_valid !== 1'b1 && got_lat < 200) begin
         @(negedge clk);
         got_lat++;
         got_cmd_ready_seen |= (cmd_ready === 1'b1);
      end
      for (int b = 0; b < BEATS; b++) begin
         waited = 0;
         while (resp_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
            got_cmd_ready_seen |= (cmd_ready === 1'b1);
         end
         if (resp_valid !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL resp_timeout: beat %0d resp_valid=%b required 1", b, resp_valid);
            return;
         end
         if (b == stall_beat) begin
            resp_ready = 1'b0;
            hold_d     = resp_data;
            hold_t     = resp_tag;
            repeat (stall_cycles) begin
               @(negedge clk);
               if (resp_data !== hold_d || resp_tag !== hold_t || resp_valid !== 1'b1) got_stable = 1'b0;
               got_cmd_ready_seen |= (cmd_ready === 1'b1);
            end
            resp_ready = 1'b1;
         end
         got_data[b] = resp_data;
         got_tag[b]  = resp_tag;
         @(negedge clk);
         if (b != BEATS - 1) got_cmd_ready_seen |= (cmd_ready === 1'b1);
      end
   endtask

   // Reset held for 130 ns and released: idle handshake levels and zeroed response.
   task automatic test_reset();
      reset = 1'b1;
      repeat (13) begin
         @(negedge clk);
         tests_run++;
         if ({cmd_ready, data_ready, resp_valid} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready_levels: got %b required 100", {cmd_ready, data_ready, resp_valid});
         end
         tests_run++;
         if (resp_data !== '0 || resp_tag !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp_zero: data=%h tag=%h required 0", resp_data, resp_tag);
         end
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         tests_run++;
         if ({cmd_ready, data_ready, resp_valid} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_levels: got %b required 100", {cmd_ready, data_ready, resp_valid});
         end
      end
   endtask

   // Write 0xA0..0xA3 to line 0x12 then read it back with a different tag.
   task automatic test_write_read();
      logic [DATA_W-1:0] exp;
      for (int b = 0; b < BEATS; b++) wr_beats[b] = DATA_W'(8'hA0 + b);
      issue_cmd(26'h12, 5'd3, 1'b1);
      send_beats(line_of(26'h12), BEATS);
      tests_run++;
      if (cmd_ready !== 1'b1 || data_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_done_levels: cmd_ready=%b data_ready=%b required 1 0", cmd_ready, data_ready);
      end
      issue_cmd(26'h12, 5'd7, 1'b0);
      collect_read(-1, 0);
      tests_run++;
      if (got_lat != RD_LAT) begin
         tests_failed++;
         $display("[TB] FAIL read_latency: got %0d cycles required %0d", got_lat, RD_LAT);
      end
      for (int b = 0; b < BEATS; b++) begin
         exp = DATA_W'(8'hA0 + b);
         tests_run++;
         if (got_data[b] !== exp || got_tag[b] !== 5'd7) begin
            tests_failed++;
            $display("[TB] FAIL write_read_beat%0d: data=%h tag=%0d required %h tag 7", b, got_data[b], got_tag[b], exp);
         end
      end
      tests_run++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL read_done_levels: resp_valid=%b cmd_ready=%b required 0 1", resp_valid, cmd_ready);
      end
   endtask

   // Hold resp_ready low for 5 cycles on beat 1: output must freeze and no beat may be lost.
   task automatic test_backpressure();
      issue_cmd(26'h12, 5'd9, 1'b0);
      collect_read(1, 5);
      tests_run++;
      if (got_stable !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL backpressure_stable: stable=%b required 1", got_stable);
      end
      for (int b = 0; b < BEATS; b++) begin
         tests_run++;
         if (got_data[b] !== model_mem[line_of(26'h12) * BEATS + b] || got_tag[b] !== 5'd9) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_beat%0d: data=%h tag=%0d required %h tag 9",
                     b, got_data[b], got_tag[b], model_mem[line_of(26'h12) * BEATS + b]);
         end
      end
   endtask

   // Address 0x405 and 0x5 share line 5; so does 0x3C05.
   task automatic test_alias();
      logic [DATA_W-1:0] written [BEATS];
      for (int b = 0; b < BEATS; b++) begin
         wr_beats[b] = rand_beat();
         written[b]  = wr_beats[b];
      end
      issue_cmd(26'h405, 5'd4, 1'b1);
      send_beats(line_of(26'h405), BEATS);
      issue_cmd(26'h5, 5'd12, 1'b0);
      collect_read(-1, 0);
      for (int b = 0; b < BEATS; b++) begin
         tests_run++;
         if (got_data[b] !== written[b] || got_tag[b] !== 5'd12) begin
            tests_failed++;
            $display("[TB] FAIL alias_beat%0d: data=%h tag=%0d required %h tag 12", b, got_data[b], got_tag[b], written[b]);
         end
      end
      issue_cmd(26'h3C05, 5'd13, 1'b0);
      collect_read(-1, 0);
      tests_run++;
      if (got_data[3] !== written[3] || got_data[0] !== written[0]) begin
         tests_failed++;
         $display("[TB] FAIL alias_high_bits: beat0=%h beat3=%h required %h %h", got_data[0], got_data[3], written[0], written[3]);
      end
   endtask

   // A second command held during a read waits until the last beat is taken, then is accepted.
   task automatic test_busy_cmd();
      issue_cmd(26'h12, 5'd1, 1'b0);
      cmd_addr  = 26'h405;
      cmd_tag   = 5'd2;
      cmd_rw    = 1'b0;
      cmd_valid = 1'b1;
      collect_read(-1, 0);
      tests_run++;
      if (got_cmd_ready_seen !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL busy_cmd_ready: seen high=%b required 0", got_cmd_ready_seen);
      end
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL busy_release: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL busy_accept: cmd_ready=%b required 0", cmd_ready);
      end
      cmd_valid = 1'b0;
      collect_read(-1, 0);
      tests_run++;
      if (got_lat != RD_LAT) begin
         tests_failed++;
         $display("[TB] FAIL busy_second_latency: got %0d required %0d", got_lat, RD_LAT);
      end
      for (int b = 0; b < BEATS; b++) begin
         tests_run++;
         if (got_data[b] !== model_mem[5 * BEATS + b] || got_tag[b] !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL busy_second_beat%0d: data=%h tag=%0d required %h tag 2",
                     b, got_data[b], got_tag[b], model_mem[5 * BEATS + b]);
         end
      end
   endtask

   // Data beats offered while idle must never be taken.
   task automatic test_idle_data();
      data_bits  = {4{32'hDEADBEEF}};
      data_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         tests_run++;
         if (data_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_data_ready: data_ready=%b required 0", data_ready);
         end
      end
      data_valid = 1'b0;
      issue_cmd(26'h12, 5'd5, 1'b0);
      collect_read(-1, 0);
      for (int b = 0; b < BEATS; b++) begin
         tests_run++;
         if (got_data[b] !== model_mem[line_of(26'h12) * BEATS + b]) begin
            tests_failed++;
            $display("[TB] FAIL idle_data_unchanged%0d: data=%h required %h", b, got_data[b], model_mem[line_of(26'h12) * BEATS + b]);
         end
      end
   endtask

   // Reset after two write beats: beats 0-1 hold new data, 2-3 keep the old line.
   task automatic test_reset_mid_write();
      logic [ADDR_W-1:0] a;
      int                line;
      a    = 26'h1A2A7;
      line = line_of(a);
      for (int b = 0; b < BEATS; b++) wr_beats[b] = rand_beat();
      issue_cmd(a, 5'd6, 1'b1);
      send_beats(line, BEATS);
      for (int b = 0; b < BEATS; b++) wr_beats[b] = rand_beat();
      issue_cmd(a, 5'd8, 1'b1);
      send_beats(line, 2);
      data_bits  = wr_beats[2];
      data_valid = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({cmd_ready, data_ready, resp_valid} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL mid_write_reset_levels: got %b required 100", {cmd_ready, data_ready, resp_valid});
      end
      reset      = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      issue_cmd(a, 5'd10, 1'b0);
      collect_read(-1, 0);
      for (int b = 0; b < BEATS; b++) begin
         tests_run++;
         if (got_data[b] !== model_mem[line * BEATS + b]) begin
            tests_failed++;
            $display("[TB] FAIL mid_write_beat%0d: data=%h required %h", b, got_data[b], model_mem[line * BEATS + b]);
         end
      end
   endtask

   // Reset during the response stops the read at once.
   task automatic test_reset_mid_read();
      issue_cmd(26'h12, 5'd11, 1'b0);
      resp_ready = 1'b0;
      repeat (RD_LAT + 1) @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (resp_valid !== 1'b0 || resp_data !== '0 || cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_read_reset: resp_valid=%b data=%h cmd_ready=%b required 0 0 1", resp_valid, resp_data, cmd_ready);
      end
      @(negedge clk);
      reset      = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_read_truncated: resp_valid=%b required 0", resp_valid);
      end
   endtask

   // Random writes to a handful of lines and random aliased reads of written lines.
   task automatic test_random();
      logic [ADDR_W-1:0] a;
      logic [TAG_W-1:0]  t;
      int                line;
      for (int i = 0; i < 10; i++) begin
         line = int'($urandom_range(0, 5)) * 97 + 3;
         a    = ADDR_W'(line) | (ADDR_W'($urandom_range(0, 255)) << IDX_W);
         for (int b = 0; b < BEATS; b++) wr_beats[b] = rand_beat();
         issue_cmd(a, TAG_W'($urandom_range(0, 31)), 1'b1);
         send_beats(line, BEATS);
         written_lines.push_back(line);
         line = written_lines[$urandom_range(0, written_lines.size() - 1)];
         a    = ADDR_W'(line) | (ADDR_W'($urandom_range(0, 255)) << IDX_W);
         t    = TAG_W'($urandom_range(0, 31));
         issue_cmd(a, t, 1'b0);
         collect_read(int'($urandom_range(0, BEATS)), int'($urandom_range(1, 4)));
         for (int b = 0; b < BEATS; b++) begin
            tests_run++;
            if (got_data[b] !== model_mem[line * BEATS + b] || got_tag[b] !== t) begin
               tests_failed++;
               $display("[TB] FAIL random_read%0d_beat%0d: data=%h tag=%0d required %h tag %0d",
                        i, b, got_data[b], got_tag[b], model_mem[line * BEATS + b], t);
            end
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      reset      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_tag    = '0;
      cmd_rw     = 1'b0;
      data_valid = 1'b0;
      data_bits  = '0;
      resp_ready = 1'b1;
      #2;
      test_reset();
      test_write_read();
      test_backpressure();
      test_alias();
      test_busy_cmd();
      test_idle_data();
      test_reset_mid_write();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Backstop in case a scenario stalls beyond its own bounds.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
